// File: rtl/hotp_pkg.sv
// -----------------------------------------------------------------------------
// hotp_pkg
//   Shared constants and FSM state type for the HOTP/TOTP truncation stage:
//   six-digit code, modulus 10^6, 12 restoring-reduction steps and a 20-bit
//   binary-to-BCD conversion.
// -----------------------------------------------------------------------------
package hotp_pkg;

    localparam int          HOTP_DIGITS  = 6;
    localparam logic [31:0] HOTP_MODULUS = 32'd1000000;
    localparam int          MOD_STEPS    = 12;
    localparam int          BCD_BITS     = 20;
    localparam int          CODE_BITS    = 4 * HOTP_DIGITS;
    localparam int          DIGEST_BITS  = 160;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXTRACT,
        ST_MOD,
        ST_BCD,
        ST_DONE
    } hotp_state_e;

endpackage

// File: rtl/hotp_bin2bcd.sv
// -----------------------------------------------------------------------------
// hotp_bin2bcd
//   Sequential double-dabble converter, one bit per cycle, BCD_BITS cycles.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     start_i     - one-cycle strobe, loads bin_i and clears the BCD register
//     bin_i       - binary value to convert (< 10^6)
//     done_o      - high in the cycle whose closing edge performs the last shift
//     bcd_o       - BCD value after the current shift; final when done_o = 1
// -----------------------------------------------------------------------------
module hotp_bin2bcd
    import hotp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [BCD_BITS-1:0]  bin_i,
    output logic                 done_o,
    output logic [CODE_BITS-1:0] bcd_o
);

    logic                 busy_q,  busy_d;
    logic [4:0]           cnt_q,   cnt_d;
    logic [BCD_BITS-1:0]  bin_q,   bin_d;
    logic [CODE_BITS-1:0] bcd_q,   bcd_d;
    logic [CODE_BITS-1:0] bcd_adj;
    logic [CODE_BITS-1:0] bcd_shift;
    logic [BCD_BITS-1:0]  bin_shift;

    // done is combinational so the parent can capture the final shifted value
    // on the same edge that completes the conversion.
    assign done_o = busy_q && (cnt_q == 5'(BCD_BITS - 1));
    assign bcd_o  = bcd_shift;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        bcd_adj = bcd_q;
        for (int i = 0; i < HOTP_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_shift, bin_shift} = {bcd_adj, bin_q} << 1;

        busy_d = busy_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            bin_d  = bin_i;
            bcd_d  = '0;
        end else if (busy_q) begin
            bin_d = bin_shift;
            bcd_d = bcd_shift;
            cnt_d = cnt_q + 5'd1;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            bin_q  <= '0;
            bcd_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
        end
    end

endmodule

// File: rtl/hotp_truncate.sv
// -----------------------------------------------------------------------------
// hotp_truncate
//   RFC 4226 dynamic truncation of a 160-bit HMAC-SHA1 digest, reduction
//   modulo 10^6 and conversion to six packed BCD digits.
//   Ports:
//     clk, rst_n         - clock, asynchronous active-low reset
//     sample_init        - start strobe, honoured only in IDLE
//     outer_sha1_digest  - digest, byte 0 in [159:152]; valid with sample_init
//     sample_ready       - one-cycle completion pulse
//     sample_output      - six BCD digits, MSD in [23:20]; held until next run
// -----------------------------------------------------------------------------
module hotp_truncate
    import hotp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_init,
    input  logic [DIGEST_BITS-1:0] outer_sha1_digest,
    output logic                   sample_ready,
    output logic [CODE_BITS-1:0]   sample_output
);

    hotp_state_e            state_q,  state_d;
    logic [DIGEST_BITS-1:0] digest_q, digest_d;
    logic [31:0]            r_q,      r_d;
    logic [3:0]             k_q,      k_d;
    logic [CODE_BITS-1:0]   out_q,    out_d;

    logic                   bcd_start;
    logic                   bcd_done;
    logic [CODE_BITS-1:0]   bcd_result;

    logic [3:0]             offset;
    logic [7:0]             lsb_idx;
    logic [31:0]            p_val;
    logic [31:0]            step_sub;

    // Bytes offset..offset+3 occupy bits [159-8*offset : 128-8*offset]; taking
    // only the low 31 bits of that window clears bit 31.
    assign offset   = digest_q[3:0];
    assign lsb_idx  = 8'd128 - {1'b0, offset, 3'b000};
    assign p_val    = {1'b0, digest_q[lsb_idx +: 31]};
    assign step_sub = HOTP_MODULUS << k_q;

    always_comb begin
        state_d   = state_q;
        digest_d  = digest_q;
        r_d       = r_q;
        k_d       = k_q;
        out_d     = out_q;
        bcd_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sample_init) begin
                    digest_d = outer_sha1_digest;
                    state_d  = ST_EXTRACT;
                end
            end
            ST_EXTRACT: begin
                r_d     = p_val;
                k_d     = 4'(MOD_STEPS - 1);
                state_d = ST_MOD;
            end
            ST_MOD: begin
                if (r_q >= step_sub) begin
                    r_d = r_q - step_sub;
                end
                if (k_q == 4'd0) begin
                    // The converter loads the fully reduced value on this edge.
                    bcd_start = 1'b1;
                    state_d   = ST_BCD;
                end else begin
                    k_d = k_q - 4'd1;
                end
            end
            ST_BCD: begin
                if (bcd_done) begin
                    out_d   = bcd_result;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the digest and datapath registers are reset along with control so
    // that reset leaves no stale key-derived data in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            digest_q <= '0;
            r_q      <= '0;
            k_q      <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            digest_q <= digest_d;
            r_q      <= r_d;
            k_q      <= k_d;
            out_q    <= out_d;
        end
    end

    hotp_bin2bcd u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (bcd_start),
        .bin_i   (r_d[BCD_BITS-1:0]),
        .done_o  (bcd_done),
        .bcd_o   (bcd_result)
    );

    assign sample_ready  = (state_q == ST_DONE);
    assign sample_output = out_q;

endmodule

// File: tb/tb_hotp_truncate.sv
// -----------------------------------------------------------------------------
// tb_hotp_truncate
//   Self-checking bench for hotp_truncate. Expected codes come from a
//   byte-level arithmetic model of RFC 4226 truncation (integer modulo and
//   decimal digit extraction).
// -----------------------------------------------------------------------------
module tb_hotp_truncate;

    logic         clk;
    logic         rst_n;
    logic         sample_init;
    logic [159:0] outer_sha1_digest;
    logic         sample_ready;
    logic [23:0]  sample_output;

    int n_checks;
    int n_fail;

    localparam logic [159:0] RFC_DIGEST  = 160'h1f8698690e02ca16618550ef7f19da8e945b555a;
    localparam logic [159:0] CNT0_DIGEST = 160'hcc93cf18508d94934c64b65d8ba7667fb7cde4b0;

    hotp_truncate dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sample_init       (sample_init),
        .outer_sha1_digest (outer_sha1_digest),
        .sample_ready      (sample_ready),
        .sample_output     (sample_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [159:0] rand160();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: pick four bytes at the dynamic offset, clear the top bit,
    // reduce modulo one million and write out six decimal digits.
    function automatic logic [23:0] model_code(input logic [159:0] d);
        logic [7:0]      b [20];
        int              off;
        longint unsigned p;
        longint unsigned r;
        logic [23:0]     code;
        for (int i = 0; i < 20; i++) b[i] = d[159 - 8*i -: 8];
        off  = int'(d[3:0]);
        p    = {32'd0, b[off], b[off+1], b[off+2], b[off+3]};
        p    = p & 64'h7fff_ffff;
        r    = p % 1000000;
        code = '0;
        for (int i = 0; i < 6; i++) begin
            code[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return code;
    endfunction

    // Starts one run and waits (bounded) for sample_ready. lat counts rising
    // edges after the sampling edge until sample_ready is seen.
    task automatic run_digest(input logic [159:0] d, output logic [23:0] res,
                              output int lat, output bit held,
                              output bit single, output bit still);
        logic [23:0] prev;
        @(negedge clk);
        prev              = sample_output;
        sample_init       = 1'b1;
        outer_sha1_digest = d;
        @(posedge clk);
        @(negedge clk);
        sample_init       = 1'b0;
        outer_sha1_digest = rand160();
        lat  = 0;
        held = 1'b1;
        while (!sample_ready && lat < 100) begin
            if (sample_output !== prev) held = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = sample_output;
        @(posedge clk);
        @(negedge clk);
        single = !sample_ready;
        still  = (sample_output === res);
    endtask

    task automatic test_reset();
        n_checks++;
        if (sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", sample_ready);
        end
        n_checks++;
        if (sample_output !== 24'h000000) begin
            n_fail++;
            $display("FAIL reset_output: got %h expected 000000", sample_output);
        end
    endtask

    task automatic test_rfc_vector();
        logic [23:0] res;
        int lat;
        bit held, single, still;
        run_digest(RFC_DIGEST, res, lat, held, single, still);
        n_checks++;
        if (res !== 24'h872921) begin
            n_fail++;
            $display("FAIL rfc_code: got %h expected 872921", res);
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL rfc_latency: got %0d edges expected 33", lat);
        end
        n_checks++;
        if (!held) begin
            n_fail++;
            $display("FAIL rfc_output_held: output changed before ready");
        end
        n_checks++;
        if (!single) begin
            n_fail++;
            $display("FAIL rfc_pulse_width: ready high %0d cycles expected 1", 2);
        end
        n_checks++;
        if (!still) begin
            n_fail++;
            $display("FAIL rfc_output_after: got %h expected 872921", sample_output);
        end
    endtask

    task automatic test_directed();
        logic [159:0] d;
        logic [23:0]  res;
        int lat;
        bit held, single, still;

        run_digest(CNT0_DIGEST, res, lat, held, single, still);
        n_checks++;
        if (res !== 24'h755224) begin
            n_fail++;
            $display("FAIL count0_code: got %h expected 755224", res);
        end

        d = rand160();
        d[159:128] = 32'h0000_0007;
        d[3:0]     = 4'h0;
        run_digest(d, res, lat, held, single, still);
        n_checks++;
        if (res !== 24'h000007) begin
            n_fail++;
            $display("FAIL offset0_code: got %h expected 000007", res);
        end

        d = rand160();
        d[39:8] = 32'hffff_ffff;
        d[3:0]  = 4'hf;
        run_digest(d, res, lat, held, single, still);
        n_checks++;
        if (res !== 24'h483647) begin
            n_fail++;
            $display("FAIL offset15_code: got %h expected 483647", res);
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL offset15_latency: got %0d expected 33", lat);
        end
    endtask

    task automatic test_random();
        logic [159:0] d;
        logic [23:0]  res;
        logic [23:0]  exp;
        int lat;
        bit held, single, still;
        for (int i = 0; i < 20; i++) begin
            d   = rand160();
            exp = model_code(d);
            run_digest(d, res, lat, held, single, still);
            n_checks++;
            if (res !== exp || lat !== 33) begin
                n_fail++;
                $display("FAIL random_%0d: digest %h got %h lat %0d expected %h lat 33",
                         i, d, res, lat, exp);
            end
        end
    endtask

    task automatic test_ignore();
        int lat;
        @(negedge clk);
        sample_init       = 1'b1;
        outer_sha1_digest = RFC_DIGEST;
        @(posedge clk);
        @(negedge clk);
        sample_init       = 1'b0;
        outer_sha1_digest = rand160();
        lat = 0;
        repeat (5) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        sample_init       = 1'b1;
        outer_sha1_digest = CNT0_DIGEST;
        @(posedge clk);
        lat++;
        @(negedge clk);
        sample_init       = 1'b0;
        while (!sample_ready && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_checks++;
        if (sample_output !== 24'h872921) begin
            n_fail++;
            $display("FAIL ignore_code: got %h expected 872921", sample_output);
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d expected 33", lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] res;
        logic [159:0] d;
        int lat;
        bit held, single, still, seen;
        @(negedge clk);
        sample_init       = 1'b1;
        outer_sha1_digest = CNT0_DIGEST;
        @(posedge clk);
        @(negedge clk);
        sample_init       = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (sample_output !== 24'h000000) begin
            n_fail++;
            $display("FAIL midreset_output: got %h expected 000000", sample_output);
        end
        n_checks++;
        if (sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b expected 0", sample_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (sample_ready) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL midreset_no_pulse: got ready pulse expected none");
        end
        d = rand160();
        run_digest(d, res, lat, held, single, still);
        n_checks++;
        if (res !== model_code(d) || lat !== 33) begin
            n_fail++;
            $display("FAIL after_reset_run: got %h lat %0d expected %h lat 33",
                     res, lat, model_code(d));
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int first_c;
        int second_c;
        bit codes_ok;
        pulses   = 0;
        first_c  = 0;
        second_c = 0;
        codes_ok = 1'b1;
        @(negedge clk);
        sample_init       = 1'b1;
        outer_sha1_digest = RFC_DIGEST;
        for (int c = 1; c <= 90; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 80) sample_init = 1'b0;
            if (sample_ready) begin
                pulses++;
                if (pulses == 1) first_c = c;
                if (pulses == 2) second_c = c;
                if (sample_output !== 24'h872921) codes_ok = 1'b0;
            end
        end
        sample_init = 1'b0;
        n_checks++;
        if (pulses !== 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d expected 2", pulses);
        end
        n_checks++;
        if (second_c - first_c !== 35) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d expected 35", second_c - first_c);
        end
        n_checks++;
        if (first_c !== 34) begin
            n_fail++;
            $display("FAIL b2b_first: got cycle %0d expected 34", first_c);
        end
        n_checks++;
        if (!codes_ok) begin
            n_fail++;
            $display("FAIL b2b_codes: got a code other than expected 872921");
        end
        repeat (50) @(negedge clk);
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        sample_init       = 1'b0;
        outer_sha1_digest = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_rfc_vector();
        test_directed();
        test_random();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hotp_truncate.md
# hotp_truncate

Dynamic-truncation and decimal-conversion stage of the TOTP datapath. Takes the 160-bit outer HMAC-SHA1 digest from the controller and applies RFC 4226 dynamic truncation: a 31-bit value, reduced modulo 10^6, converted to six packed BCD digits. Sits directly downstream of the controller's outer-hash step and returns the code through the `sample_init` / `sample_ready` handshake.

## Interface
Parameters:
- None. Fixed constants (6 digits, modulus 1 000 000) live in `hotp_pkg`.

Ports:
- `clk` in 1: single system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_init` in 1: start strobe, one cycle, sampled only in IDLE.
- `outer_sha1_digest` in 160: HMAC-SHA1 result; byte 0 = [159:152], byte 19 = [7:0]. Valid in the cycle `sample_init` is high.
- `sample_ready` out 1: one-cycle completion pulse.
- `sample_output` out 24: six BCD digits, most significant digit in [23:20]. Held until the next completion.

## Operation
- States: IDLE, EXTRACT, MOD, BCD, DONE.
- **IDLE**
  - On `sample_init`=1, latch the digest into an internal register and go to EXTRACT.
- **EXTRACT**
  - offset = digest[3:0].
  - P = {byte[offset], byte[offset+1], byte[offset+2], byte[offset+3]} with bit 31 cleared (31-bit value).
  - offset range is 0..15, so byte offset+3 never exceeds 18 and no wrap-around occurs.
  - Go to MOD with k=11.
- **MOD**: 12 cycles of restoring reduction, k = 11 down to 0.
  - If R >= 1 000 000·2^k, then R -= 1 000 000·2^k.
  - 1 000 000·2^11 < 2^31, so 12 steps are sufficient.
  - Comparator is 32-bit; the final R < 10^6 fits in 20 bits.
- **BCD**: 20 cycles of double-dabble on the 20-bit remainder.
  - Each cycle: add 3 to every BCD nibble >= 5, then shift left one bit.
  - Produces a 24-bit result; leading zeros are kept.
- **DONE**
  - Register the result into `sample_output`.
  - Assert `sample_ready` for exactly this cycle.
  - Go to IDLE.
- `sample_init` outside IDLE is ignored. No queuing; the digest input is not re-sampled.
- If `sample_init` is held high continuously, a new run starts from the IDLE cycle after DONE.

## Timing
- Reset values: `sample_ready`=0, `sample_output`=24'h000000, state IDLE, internal registers 0.
- Reset asserted mid-operation aborts immediately. `sample_output` returns to 0 and no `sample_ready` pulse is produced.
- Latency, counting edge E0 as the edge that samples `sample_init` high:
  - EXTRACT at E0→E1.
  - MOD occupies E1..E12.
  - BCD occupies E13..E32.
  - `sample_ready`=1 and the new `sample_output` are valid in the cycle after E33, i.e. 34 cycles after start.
- Minimum start-to-start spacing is 35 cycles.
- `sample_output` changes only on the DONE edge (or on reset). It is stable whenever `sample_ready`=1 and afterwards.
- Compatible with the controller's BUSY5 wait: the controller pulses `sample_init` once and waits for `sample_ready`.

## Structure
- `hotp_pkg` holds:
  - state enum;
  - `HOTP_DIGITS`=6;
  - `HOTP_MODULUS`=32'd1000000;
  - `MOD_STEPS`=12;
  - `BCD_BITS`=20.
- One natural sub-module, `hotp_bin2bcd`: sequential 20-bit double-dabble with start/done.
  - Owns the BCD state and its 5-bit step counter.
  - The parent FSM treats its done as the BCD→DONE transition.
- The parent holds the digest register, offset mux, MOD datapath and 4-bit k counter.

## Test plan
- **RFC 4226 §5.4 vector**
  - Stimulus: digest 0x1f8698690e02ca16618550ef7f19da8e945b555a.
  - Response: offset 10, P=0x50ef7f19; `sample_output`=24'h872921 with a single `sample_ready` pulse 34 cycles after start.
- **RFC 4226 count-0 vector**
  - Stimulus: HMAC cc93cf18508d94934c64b65d8ba7667fb7cde4b0.
  - Response: `sample_output`=24'h755224.
- **Offset 0 plus leading-zero handling**
  - Stimulus: digest with bytes 0..3 = 00 00 00 07 and last nibble 0.
  - Response: `sample_output`=24'h000007.
- **Offset 15 plus MSB mask**
  - Stimulus: bytes 15..18 = FF FF FF FF and digest[3:0]=F.
  - Response: P=2147483647, `sample_output`=24'h483647.
- **Ignore and reset**
  - Stimulus: `sample_init` re-pulsed with a different digest during MOD.
  - Response: the result reflects the first digest only.
  - Stimulus: `rst_n` dropped during BCD.
  - Response: outputs go to 0 with no `sample_ready`; the next run completes normally.
- **Back-to-back runs**
  - Stimulus: `sample_init` held high for 80 cycles with the 872921 digest.
  - Response: two `sample_ready` pulses 35 cycles apart, both with 24'h872921.
